// File: rtl/dsp_pcm_slave_pkg.sv
// dsp_pcm_slave_pkg: shared register map, encodings and helpers for the DSP-mode PCM slave
package dsp_pcm_slave_pkg;
    localparam logic [7:0] CONFIG_ADDR    = 8'h00;
    localparam logic [7:0] STATUS_ADDR    = 8'h04;
    localparam logic [7:0] FRAME_CNT_ADDR = 8'h08;
    localparam logic [31:0] UNMAPPED_DATA = 32'hdeadbabe;
    typedef enum logic [1:0] {BPS_16, BPS_20, BPS_24, BPS_32} bps_e;
    typedef enum logic [1:0] {IDLE_S, WAIT_FS_S, LCHAN_S, RCHAN_S} state_e;
    function automatic logic [4:0] bw_m1_of(input bps_e b);
        return b == BPS_16 ? 5'd15 : b == BPS_20 ? 5'd19 : b == BPS_24 ? 5'd23 : 5'd31;
    endfunction
    function automatic logic [31:0] sext(input logic [31:0] v, input bps_e b);
        return b == BPS_16 ? {{16{v[15]}}, v[15:0]} :
               b == BPS_20 ? {{12{v[19]}}, v[19:0]} :
               b == BPS_24 ? {{8{v[23]}}, v[23:0]} : v;
    endfunction
endpackage

// File: rtl/dsp_pcm_slave_if.sv
// dsp_pcm_slave_if: local-bus register port
// Signals: wr_en/rd_en strobes, addr, wr_data from the master; wr_valid/rd_valid acks and rd_data from the slave.
interface dsp_pcm_slave_if #(parameter int DATA_W = 32, parameter int ADDR_W = 8);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    modport master (output wr_en, rd_en, addr, wr_data, input wr_valid, rd_valid, rd_data);
    modport slave (input wr_en, rd_en, addr, wr_data, output wr_valid, rd_valid, rd_data);
endinterface

// File: rtl/dsp_pcm_slave_sync_edge_det.sv
// sync_edge_det: N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level
// Ports: clk, rst_n (async, active-low); d async input; q synchronized level; rise/fall edge pulses.
module sync_edge_det #(parameter int STAGES = 2) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sr;
    logic prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            prev <= 1'b0;
        end else begin
            sr <= STAGES'({sr, d});
            prev <= q;
        end
    end
    assign q = sr[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/dsp_pcm_slave.sv
// dsp_pcm_slave: slave-side DSP-mode (LRP=1) audio serial port with local-bus control registers
// Ports: clk, rst_n (async, active-low); lb local-bus register port; BCLK_IN/LRCK_IN/SDI from the master;
//   SDO to the master; rx_pcm_valid/rx_lpcm_data/rx_rpcm_data received pair; tx_pcm_nxt/tx_lpcm_data/tx_rpcm_data send pair.
module dsp_pcm_slave
    import dsp_pcm_slave_pkg::*;
#(
    parameter int LB_DATA_W   = 32,
    parameter int LB_ADDR_W   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FRM_CNTR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dsp_pcm_slave_if.slave    lb,
    input  logic              BCLK_IN,
    input  logic              LRCK_IN,
    input  logic              SDI,
    output logic              SDO,
    output logic              rx_pcm_valid,
    output logic [31:0]       rx_lpcm_data,
    output logic [31:0]       rx_rpcm_data,
    output logic              tx_pcm_nxt,
    input  logic [31:0]       tx_lpcm_data,
    input  logic [31:0]       tx_rpcm_data
);
    state_e state, state_nxt;
    bps_e cfg_bps, act_bps;
    logic cfg_en, err, done, cfg_wr;
    logic start, smp, fin, ferr, drv, fs;
    logic bclk_rise, bclk_fall, lrck_q, bclk_q_unused, unused_wr_bits;
    logic [1:0] lrck_edge_unused;
    logic [SYNC_STAGES-1:0] sdi_sr;
    logic [4:0] cnt, bw_m1, idx;
    logic [31:0] tx_l, tx_r, rx_l, rx_r;
    logic [FRM_CNTR_W-1:0] frame_cnt;
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .rst_n(rst_n), .d(BCLK_IN), .q(bclk_q_unused), .rise(bclk_rise), .fall(bclk_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck (
        .clk(clk), .rst_n(rst_n), .d(LRCK_IN), .q(lrck_q), .rise(lrck_edge_unused[0]), .fall(lrck_edge_unused[1])
    );
    assign fs = bclk_rise & lrck_q;
    assign bw_m1 = bw_m1_of(act_bps);
    assign idx = bw_m1 - cnt;
    assign cfg_wr = lb.wr_en && lb.addr == LB_ADDR_W'(CONFIG_ADDR);
    assign unused_wr_bits = ^{lb.wr_data[LB_DATA_W-1:5], lb.wr_data[1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE_S;
        else state <= state_nxt;
    end
    // A frame sync seen mid-frame restarts the frame and flags an error.
    always_comb begin
        state_nxt = state;
        start = 1'b0;
        smp = 1'b0;
        fin = 1'b0;
        ferr = 1'b0;
        drv = 1'b0;
        if (!cfg_en) state_nxt = IDLE_S;
        else case (state)
            IDLE_S: state_nxt = WAIT_FS_S;
            WAIT_FS_S: begin
                start = fs;
                state_nxt = fs ? LCHAN_S : WAIT_FS_S;
            end
            default: begin
                drv = bclk_fall;
                start = fs;
                ferr = fs;
                smp = bclk_rise & ~fs;
                fin = smp && cnt == bw_m1 && state == RCHAN_S;
                state_nxt = fs ? LCHAN_S : (smp && cnt == bw_m1) ? (state == LCHAN_S ? RCHAN_S : WAIT_FS_S) : state;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_en <= 1'b0;
            cfg_bps <= BPS_16;
            act_bps <= BPS_16;
            err <= 1'b0;
            done <= 1'b0;
            cnt <= '0;
            tx_l <= '0;
            tx_r <= '0;
            rx_l <= '0;
            rx_r <= '0;
            frame_cnt <= '0;
            sdi_sr <= '0;
            SDO <= 1'b0;
            rx_pcm_valid <= 1'b0;
            rx_lpcm_data <= '0;
            rx_rpcm_data <= '0;
            tx_pcm_nxt <= 1'b0;
            lb.wr_valid <= 1'b0;
            lb.rd_valid <= 1'b0;
            lb.rd_data <= '0;
        end else begin
            sdi_sr <= SYNC_STAGES'({sdi_sr, SDI});
            lb.wr_valid <= lb.wr_en;
            lb.rd_valid <= lb.rd_en;
            if (cfg_wr) begin
                cfg_en <= lb.wr_data[0];
                cfg_bps <= bps_e'(lb.wr_data[3:2]);
            end
            if (lb.rd_en)
                lb.rd_data <= lb.addr == LB_ADDR_W'(CONFIG_ADDR) ? LB_DATA_W'({cfg_bps, 1'b0, cfg_en}) :
                              lb.addr == LB_ADDR_W'(STATUS_ADDR) ? LB_DATA_W'({err, state}) :
                              lb.addr == LB_ADDR_W'(FRAME_CNT_ADDR) ? LB_DATA_W'(frame_cnt) : LB_DATA_W'(UNMAPPED_DATA);
            err <= ferr | (err & ~(cfg_wr & lb.wr_data[4]));
            tx_pcm_nxt <= start;
            done <= fin;
            rx_pcm_valid <= done;
            if (done) begin
                rx_lpcm_data <= sext(rx_l, act_bps);
                rx_rpcm_data <= sext(rx_r, act_bps);
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (start) begin
                act_bps <= cfg_bps;
                tx_l <= tx_lpcm_data;
                tx_r <= tx_rpcm_data;
                cnt <= '0;
            end
            if (smp) begin
                cnt <= cnt == bw_m1 ? '0 : cnt + 1'b1;
                if (state == LCHAN_S) rx_l <= {rx_l[30:0], sdi_sr[SYNC_STAGES-1]};
                else rx_r <= {rx_r[30:0], sdi_sr[SYNC_STAGES-1]};
            end
            if (drv) SDO <= state == LCHAN_S ? tx_l[idx] : tx_r[idx];
            if (fin || state == IDLE_S || !cfg_en) begin
                SDO <= 1'b0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dsp_pcm_slave.sv
// tb_dsp_pcm_slave: self-checking bench acting as the DSP-mode bus master for dsp_pcm_slave
module tb_dsp_pcm_slave;
    import dsp_pcm_slave_pkg::*;
    localparam int H = 4;
    typedef struct {
        int bw;
        logic [31:0] sdi_l, sdi_r, exp_l, exp_r, tx_l, tx_r, sdo_l, sdo_r;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lrck = 1'b0, sdi_drv = 1'b0, loop = 1'b0;
    logic sdo, rx_valid, tx_nxt, sdi_w, sdo_or;
    logic [31:0] rx_l, rx_r, tx_l = '0, tx_r = '0, got_l = '0, got_r = '0;
    logic [63:0] sdo_sh;
    int errors = 0, checks = 0, rx_cnt = 0, nxt_cnt = 0;
    vec_t vt[4];
    dsp_pcm_slave_if #(.DATA_W(32), .ADDR_W(8)) lb ();
    dsp_pcm_slave dut (
        .clk(clk), .rst_n(rst_n), .lb(lb), .BCLK_IN(bclk), .LRCK_IN(lrck), .SDI(sdi_w), .SDO(sdo),
        .rx_pcm_valid(rx_valid), .rx_lpcm_data(rx_l), .rx_rpcm_data(rx_r),
        .tx_pcm_nxt(tx_nxt), .tx_lpcm_data(tx_l), .tx_rpcm_data(tx_r)
    );
    assign sdi_w = loop ? sdo : sdi_drv;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            got_l = rx_l;
            got_r = rx_r;
        end
        if (tx_nxt) nxt_cnt++;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end
    function automatic logic [31:0] model_rx(input logic [31:0] v, input int bw);
        longint m, x;
        if (bw >= 32) return v;
        m = longint'(1) << bw;
        x = longint'(v) % m;
        if (x >= m / 2) x -= m;
        return 32'(x);
    endfunction
    function automatic logic [31:0] cfg_word(input int bw, input logic en);
        logic [1:0] b;
        b = bw == 16 ? 2'd0 : bw == 20 ? 2'd1 : bw == 24 ? 2'd2 : 2'd3;
        return {28'h0, b, 1'b0, en};
    endfunction
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask
    task automatic lb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        lb.wr_en = 1'b1;
        lb.addr = a;
        lb.wr_data = d;
        @(negedge clk);
        lb.wr_en = 1'b0;
        chk("wr_valid", 32'(lb.wr_valid), 32'd1);
    endtask
    task automatic rd_chk(input string n, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        lb.rd_en = 1'b1;
        lb.addr = a;
        @(negedge clk);
        lb.rd_en = 1'b0;
        chk({n, "_ack"}, 32'(lb.rd_valid), 32'd1);
        chk(n, lb.rd_data, exp);
    endtask
    task automatic bit_(input logic lr, input logic d, output logic s);
        @(negedge clk);
        bclk = 1'b0;
        lrck = lr;
        sdi_drv = d;
        repeat (H) @(negedge clk);
        bclk = 1'b1;
        s = sdo;
        repeat (H) @(negedge clk);
    endtask
    task automatic idle_bit(input logic lr);
        logic s;
        bit_(lr, 1'b0, s);
    endtask
    task automatic send_bits(input int bw, input logic [31:0] l, input logic [31:0] r, input int from, input int to);
        logic s, d;
        for (int i = from; i < to; i++) begin
            if (i < bw) d = l[bw-1-i];
            else d = r[2*bw-1-i];
            bit_(1'b0, d, s);
            sdo_sh = {sdo_sh[62:0], s};
            sdo_or |= s;
        end
    endtask
    task automatic send_frame(input int bw, input logic [31:0] l, input logic [31:0] r);
        idle_bit(1'b1);
        sdo_sh = '0;
        send_bits(bw, l, r, 0, 2 * bw);
        idle_bit(1'b0);
        idle_bit(1'b0);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    initial begin
        int r0, n0;
        logic [31:0] l1, r1, l2, r2;
        logic [63:0] m;
        vt[0] = '{16, 32'h8001, 32'h7FFE, 32'hFFFF8001, 32'h00007FFE, 32'h1234ABCD, 32'hFFFF0F0F, 32'hABCD, 32'h0F0F};
        vt[1] = '{24, 32'h800000, 32'h123456, 32'hFF800000, 32'h00123456, 32'h00A5A5A5, 32'h005A5A5A, 32'hA5A5A5, 32'h5A5A5A};
        vt[2] = '{20, 32'h80000, 32'h7FFFF, 32'hFFF80000, 32'h0007FFFF, 32'hFFF12345, 32'h000ABCDE, 32'h12345, 32'hABCDE};
        vt[3] = '{32, 32'h80000001, 32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h01234567, 32'hDEADBEEF, 32'h01234567};
        lb.wr_en = 1'b0;
        lb.rd_en = 1'b0;
        lb.addr = '0;
        lb.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_nxt", 32'(tx_nxt), 32'd0);
        chk("rst_rx_l", rx_l, 32'd0);
        chk("rst_rx_r", rx_r, 32'd0);
        chk("rst_rd_data", lb.rd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("rst_config", CONFIG_ADDR, 32'd0);
        rd_chk("rst_status", STATUS_ADDR, 32'd0);
        rd_chk("rst_frame_cnt", FRAME_CNT_ADDR, 32'd0);
        rd_chk("unmapped", 8'h10, 32'hdeadbabe);
        for (int i = 0; i < 4; i++) begin
            lb_write(CONFIG_ADDR, cfg_word(vt[i].bw, 1'b1));
            tx_l = vt[i].tx_l;
            tx_r = vt[i].tx_r;
            r0 = rx_cnt;
            n0 = nxt_cnt;
            send_frame(vt[i].bw, vt[i].sdi_l, vt[i].sdi_r);
            m = (64'd1 << vt[i].bw) - 64'd1;
            chk("vec_rx_count", 32'(rx_cnt - r0), 32'd1);
            chk("vec_rx_l", got_l, vt[i].exp_l);
            chk("vec_rx_r", got_r, vt[i].exp_r);
            chk("vec_sdo_l", 32'((sdo_sh >> vt[i].bw) & m), vt[i].sdo_l);
            chk("vec_sdo_r", 32'(sdo_sh & m), vt[i].sdo_r);
            chk("vec_tx_nxt", 32'(nxt_cnt - n0), 32'd1);
            chk("vec_sdo_gap", 32'(sdo), 32'd0);
            rd_chk("vec_frame_cnt", FRAME_CNT_ADDR, 32'(i + 1));
        end
        lb_write(CONFIG_ADDR, cfg_word(16, 1'b1));
        idle_bit(1'b1);
        send_bits(16, 32'hFFFF, 32'hFFFF, 0, 8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sdo", 32'(sdo), 32'd0);
        do_reset();
        rd_chk("midrst_frame_cnt", FRAME_CNT_ADDR, 32'd0);
        rd_chk("midrst_status", STATUS_ADDR, 32'd0);
        lb_write(CONFIG_ADDR, cfg_word(16, 1'b1));
        loop = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tx_l = $urandom;
            tx_r = $urandom;
            r0 = rx_cnt;
            send_frame(16, 32'h0, 32'h0);
            chk("loop_rx_count", 32'(rx_cnt - r0), 32'd1);
            chk("loop_rx_l", got_l, model_rx(tx_l, 16));
            chk("loop_rx_r", got_r, model_rx(tx_r, 16));
        end
        loop = 1'b0;
        rd_chk("loop_frame_cnt", FRAME_CNT_ADDR, 32'd100);
        l1 = $urandom;
        r1 = $urandom;
        l2 = $urandom;
        r2 = $urandom;
        r0 = rx_cnt;
        n0 = nxt_cnt;
        idle_bit(1'b1);
        send_bits(16, l1, r1, 0, 10);
        send_frame(16, l2, r2);
        chk("ferr_rx_count", 32'(rx_cnt - r0), 32'd1);
        chk("ferr_rx_l", got_l, model_rx(l2, 16));
        chk("ferr_rx_r", got_r, model_rx(r2, 16));
        chk("ferr_tx_nxt", 32'(nxt_cnt - n0), 32'd2);
        rd_chk("ferr_status", STATUS_ADDR, 32'h5);
        rd_chk("ferr_frame_cnt", FRAME_CNT_ADDR, 32'd101);
        lb_write(CONFIG_ADDR, 32'h11);
        rd_chk("ferr_cleared", STATUS_ADDR, 32'h1);
        l1 = $urandom;
        r1 = $urandom;
        r0 = rx_cnt;
        idle_bit(1'b1);
        send_bits(16, l1, r1, 0, 5);
        lb_write(CONFIG_ADDR, cfg_word(32, 1'b1));
        send_bits(16, l1, r1, 5, 32);
        idle_bit(1'b0);
        idle_bit(1'b0);
        chk("bps_old_count", 32'(rx_cnt - r0), 32'd1);
        chk("bps_old_l", got_l, model_rx(l1, 16));
        chk("bps_old_r", got_r, model_rx(r1, 16));
        l2 = 32'h8000_0000 | $urandom;
        r2 = $urandom;
        send_frame(32, l2, r2);
        chk("bps_new_count", 32'(rx_cnt - r0), 32'd2);
        chk("bps_new_l", got_l, l2);
        chk("bps_new_r", got_r, r2);
        lb_write(CONFIG_ADDR, cfg_word(16, 1'b1));
        l1 = $urandom;
        r1 = $urandom;
        tx_l = 32'hFFFF;
        tx_r = 32'hFFFF;
        r0 = rx_cnt;
        idle_bit(1'b1);
        send_bits(16, l1, r1, 0, 21);
        lb_write(CONFIG_ADDR, 32'h0);
        @(negedge clk);
        chk("endrop_sdo", 32'(sdo), 32'd0);
        rd_chk("endrop_status", STATUS_ADDR, 32'h0);
        sdo_or = 1'b0;
        send_bits(16, l1, r1, 21, 32);
        idle_bit(1'b0);
        idle_bit(1'b0);
        chk("endrop_sdo_rest", 32'(sdo_or), 32'd0);
        chk("endrop_rx_count", 32'(rx_cnt - r0), 32'd0);
        lb_write(CONFIG_ADDR, cfg_word(16, 1'b1));
        l2 = $urandom;
        r2 = $urandom;
        send_frame(16, l2, r2);
        chk("reen_rx_count", 32'(rx_cnt - r0), 32'd1);
        chk("reen_rx_l", got_l, model_rx(l2, 16));
        chk("reen_rx_r", got_r, model_rx(r2, 16));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
